// File: rtl/soc_tracker.sv
// Coulomb-counting SOC tracker: integrates per-cell currents into SOC registers
// using one shared FP multiplier/adder pair stepped over the four cells.
module soc_tracker #(
    parameter logic [31:0] SCALE_K  = 32'h3D800000,
    parameter logic [31:0] INIT_SOC = 32'h3F800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] i1,
    input  logic [31:0] i2,
    input  logic [31:0] i3,
    input  logic [31:0] i4,
    input  logic        load_en,
    input  logic [31:0] load_soc1,
    input  logic [31:0] load_soc2,
    input  logic [31:0] load_soc3,
    input  logic [31:0] load_soc4,
    output logic [31:0] soc1,
    output logic [31:0] soc2,
    output logic [31:0] soc3,
    output logic [31:0] soc4,
    output logic        out_valid,
    output logic [3:0]  full,
    output logic [3:0]  empty
);

    typedef enum logic [3:0] {
        IDLE, MUL0, UPD0, MUL1, UPD1, MUL2, UPD2, MUL3, UPD3, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] soc_q [4];
    logic [31:0] cur_q [4];
    logic [31:0] p_q;
    logic [3:0]  full_q, empty_q;

    logic [1:0]  idx;
    logic        is_mul, is_upd;
    logic [31:0] i_cur, soc_cur, mul_res;
    logic [24:0] prod_hi;
    logic [7:0]  pexp;
    logic [31:0] b, x, y, s, soc_new;
    logic [7:0]  dexp;
    logic [23:0] mx, my, diff;
    logic [24:0] sum;
    logic [22:0] norm;
    logic [4:0]  lz;
    logic        found, i_zero, full_new, empty_new;

    always_comb begin
        idx    = 2'd0;
        is_mul = 1'b0;
        is_upd = 1'b0;
        unique case (state_q)
            MUL0: begin is_mul = 1'b1; idx = 2'd0; end
            UPD0: begin is_upd = 1'b1; idx = 2'd0; end
            MUL1: begin is_mul = 1'b1; idx = 2'd1; end
            UPD1: begin is_upd = 1'b1; idx = 2'd1; end
            MUL2: begin is_mul = 1'b1; idx = 2'd2; end
            UPD2: begin is_upd = 1'b1; idx = 2'd2; end
            MUL3: begin is_mul = 1'b1; idx = 2'd3; end
            UPD3: begin is_upd = 1'b1; idx = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid && !load_en) state_d = MUL0;
            MUL0:    state_d = UPD0;
            UPD0:    state_d = MUL1;
            MUL1:    state_d = UPD1;
            UPD1:    state_d = MUL2;
            MUL2:    state_d = UPD2;
            UPD2:    state_d = MUL3;
            MUL3:    state_d = UPD3;
            UPD3:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i_cur   = cur_q[idx];
    assign soc_cur = soc_q[idx];
    assign i_zero  = (i_cur[30:0] == 31'd0);

    // Product keeps only the bits needed after a one-place normalise; truncated.
    always_comb begin
        prod_hi = 25'((48'({1'b1, SCALE_K[22:0]}) * 48'({1'b1, i_cur[22:0]})) >> 23);
        pexp    = SCALE_K[30:23] + i_cur[30:23] - 8'd127;
        if (prod_hi[24])
            mul_res = {SCALE_K[31] ^ i_cur[31], pexp + 8'd1, prod_hi[23:1]};
        else
            mul_res = {SCALE_K[31] ^ i_cur[31], pexp, prod_hi[22:0]};
    end

    always_comb begin
        b     = {~p_q[31], p_q[30:0]};
        x     = soc_cur;
        y     = b;
        dexp  = 8'd0;
        mx    = 24'd0;
        my    = 24'd0;
        diff  = 24'd0;
        sum   = 25'd0;
        norm  = 23'd0;
        lz    = 5'd0;
        found = 1'b0;
        s     = 32'd0;
        if (soc_cur[30:0] == 31'd0) begin
            s = b;
        end else if (soc_cur[30:0] == b[30:0] && soc_cur[31] != b[31]) begin
            s = 32'd0;
        end else begin
            if (soc_cur[30:0] < b[30:0]) begin
                x = b;
                y = soc_cur;
            end
            dexp = x[30:23] - y[30:23];
            mx   = {1'b1, x[22:0]};
            my   = (dexp >= 8'd24) ? 24'd0 : ({1'b1, y[22:0]} >> dexp);
            if (x[31] == y[31]) begin
                sum = {1'b0, mx} + {1'b0, my};
                if (sum[24])
                    s = {x[31], x[30:23] + 8'd1, sum[23:1]};
                else
                    s = {x[31], x[30:23], sum[22:0]};
            end else begin
                diff = mx - my;
                for (int j = 23; j >= 0; j--) begin
                    if (!found && diff[j]) begin
                        lz    = 5'(23 - j);
                        found = 1'b1;
                    end
                end
                norm = 23'(diff << lz);
                if ({3'b0, lz} >= x[30:23])
                    s = 32'd0;
                else
                    s = {x[31], x[30:23] - {3'b0, lz}, norm};
            end
        end
    end

    always_comb begin
        soc_new   = s;
        full_new  = 1'b0;
        empty_new = 1'b0;
        if (s[31] || s[30:0] == 31'd0) begin
            soc_new   = 32'd0;
            empty_new = 1'b1;
        end else if (s[30:0] >= 31'h3F800000) begin
            soc_new  = 32'h3F800000;
            full_new = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= 32'd0;
            full_q  <= 4'd0;
            empty_q <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                soc_q[k] <= INIT_SOC;
                cur_q[k] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && load_en) begin
                soc_q[0] <= load_soc1;
                soc_q[1] <= load_soc2;
                soc_q[2] <= load_soc3;
                soc_q[3] <= load_soc4;
                full_q   <= 4'd0;
                empty_q  <= 4'd0;
            end else if (state_q == IDLE && in_valid) begin
                cur_q[0] <= i1;
                cur_q[1] <= i2;
                cur_q[2] <= i3;
                cur_q[3] <= i4;
            end
            if (is_mul)
                p_q <= mul_res;
            if (is_upd && !i_zero) begin
                soc_q[idx]   <= soc_new;
                full_q[idx]  <= full_new;
                empty_q[idx] <= empty_new;
            end
        end
    end

    assign soc1      = soc_q[0];
    assign soc2      = soc_q[1];
    assign soc3      = soc_q[2];
    assign soc4      = soc_q[3];
    assign full      = full_q;
    assign empty     = empty_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_soc_tracker.sv
// Bench for soc_tracker: SOC kept as integer 1/256 units, currents as n/16,
// so every expected float is exact and built from the model's integers.
module tb_soc_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, load_en, out_valid;
    logic [31:0] i1, i2, i3, i4;
    logic [31:0] load_soc1, load_soc2, load_soc3, load_soc4;
    logic [31:0] soc1, soc2, soc3, soc4;
    logic [3:0]  full, empty;

    int n_err = 0;
    int n_chk = 0;
    int u[4];
    bit mf[4], me[4];
    int nn[4];
    bit nz[4];
    int lu[4];

    soc_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .load_en(load_en),
        .load_soc1(load_soc1), .load_soc2(load_soc2),
        .load_soc3(load_soc3), .load_soc4(load_soc4),
        .soc1(soc1), .soc2(soc2), .soc3(soc3), .soc4(soc4),
        .out_valid(out_valid), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Value num * 2^-shift as an IEEE single (num >= 0, small).
    function automatic logic [31:0] to_fp(input int num, input int shift);
        int p;
        logic [7:0] e;
        if (num == 0) return 32'h0;
        p = 0;
        for (int k = 0; k < 31; k++)
            if (num >= (1 << k)) p = k;
        e = 8'(127 + p - shift);
        return {1'b0, e, 23'(num << (23 - p))};
    endfunction

    function automatic logic [31:0] cur_bits(input int n, input bit negz);
        logic [31:0] m;
        if (n == 0) return negz ? 32'h80000000 : 32'h0;
        m = to_fp(n < 0 ? -n : n, 4);
        m[31] = (n < 0);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic check_state(input string tag);
        logic [3:0] ef, ee;
        for (int k = 0; k < 4; k++) begin
            ef[k] = mf[k];
            ee[k] = me[k];
        end
        chk({tag, "_soc1"}, soc1, to_fp(u[0], 8));
        chk({tag, "_soc2"}, soc2, to_fp(u[1], 8));
        chk({tag, "_soc3"}, soc3, to_fp(u[2], 8));
        chk({tag, "_soc4"}, soc4, to_fp(u[3], 8));
        chk({tag, "_full"}, {28'd0, full}, {28'd0, ef});
        chk({tag, "_empty"}, {28'd0, empty}, {28'd0, ee});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            u[k] = 256; mf[k] = 0; me[k] = 0;
        end
    endtask

    task automatic model_apply();
        int v;
        for (int k = 0; k < 4; k++) begin
            if (nn[k] != 0) begin
                v = u[k] - nn[k];
                if (v <= 0) begin
                    u[k] = 0; me[k] = 1; mf[k] = 0;
                end else if (v >= 256) begin
                    u[k] = 256; mf[k] = 1; me[k] = 0;
                end else begin
                    u[k] = v; mf[k] = 0; me[k] = 0;
                end
            end
        end
    endtask

    task automatic do_load(input bit with_valid, input string tag);
        @(negedge clk);
        load_en   = 1'b1;
        in_valid  = with_valid;
        i1 = cur_bits(16, 0); i2 = cur_bits(-16, 0);
        i3 = cur_bits(8, 0);  i4 = cur_bits(4, 0);
        load_soc1 = to_fp(lu[0], 8);
        load_soc2 = to_fp(lu[1], 8);
        load_soc3 = to_fp(lu[2], 8);
        load_soc4 = to_fp(lu[3], 8);
        @(negedge clk);
        load_en  = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            u[k] = lu[k]; mf[k] = 0; me[k] = 0;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
        check_state(tag);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_sample(input bit hold, input int load_cyc,
                              input int rst_cyc, input string tag);
        int cyc, busy_bad, ov_seen;
        bit got;
        @(negedge clk);
        chk({tag, "_ready_pre"}, {31'd0, in_ready}, 32'd1);
        i1 = cur_bits(nn[0], nz[0]);
        i2 = cur_bits(nn[1], nz[1]);
        i3 = cur_bits(nn[2], nz[2]);
        i4 = cur_bits(nn[3], nz[3]);
        in_valid = 1'b1;
        @(posedge clk);
        cyc = 0; got = 0; busy_bad = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                i1 = $urandom; i2 = $urandom; i3 = $urandom; i4 = $urandom;
            end
            if (!hold || cyc >= 9) in_valid = 1'b0;
            if (cyc == rst_cyc) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk({tag, "_rst_ov"}, {31'd0, out_valid}, 32'd0);
                chk({tag, "_rst_ready"}, {31'd0, in_ready}, 32'd1);
                check_state({tag, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                ov_seen = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (out_valid) ov_seen++;
                end
                chk({tag, "_rst_no_ov"}, ov_seen, 0);
                chk({tag, "_rst_ready2"}, {31'd0, in_ready}, 32'd1);
                check_state({tag, "_after"});
                return;
            end
            if (cyc == load_cyc) begin
                load_en = 1'b1;
                load_soc1 = 32'h3E800000; load_soc2 = 32'h3E800000;
                load_soc3 = 32'h3E800000; load_soc4 = 32'h3E800000;
            end else begin
                load_en = 1'b0;
            end
            if (out_valid) got = 1;
            else if (in_ready) busy_bad++;
        end
        load_en = 1'b0;
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_busy"}, busy_bad, 0);
        model_apply();
        check_state(tag);
        @(negedge clk);
        chk({tag, "_ready_post"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_ov_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; load_en = 1'b0;
        i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        load_soc1 = '0; load_soc2 = '0; load_soc3 = '0; load_soc4 = '0;
        nz = '{0, 0, 0, 0};
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("reset");
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_ov", {31'd0, out_valid}, 32'd0);

        nn = '{16, 16, 16, 16};
        run_sample(0, 0, 0, "discharge");

        lu = '{128, 240, 256, 256};
        do_load(0, "load3");
        nn = '{-32, -32, 0, 0};
        nz = '{0, 0, 0, 1};
        run_sample(0, 0, 0, "charge");
        nz = '{0, 0, 0, 0};

        lu = '{16, 16, 256, 256};
        do_load(0, "load4");
        nn = '{16, 32, 0, 0};
        run_sample(0, 0, 0, "lowclamp");
        nn = '{-16, 0, 0, 0};
        run_sample(0, 0, 0, "zeropath");

        lu = '{200, 100, 50, 0};
        do_load(1, "loadwins");
        nn = '{3, -5, 7, -9};
        run_sample(1, 5, 0, "holdload");

        nn = '{8, 8, 8, 8};
        run_sample(0, 0, 4, "midreset");

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 4; k++) lu[k] = int'($urandom_range(0, 256));
                do_load(0, "rload");
            end
            for (int k = 0; k < 4; k++) begin
                nn[k] = int'($urandom_range(0, 64)) - 32;
                nz[k] = 1'($urandom_range(0, 1));
            end
            run_sample(0, 0, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
